// File: rtl/llr_frame_assembler_if.sv
// ---------------------------------------------------------------------------
// llr_frame_assembler_if
// Bundles the LLR stream handshake and the frame output bus of
// llr_frame_assembler.
//   llr_in / llr_in_valid / llr_in_ready : serial LLR word stream
//   decoder_ready                         : downstream decoder can take a frame
//   out_valid                             : one-cycle frame strobe
//   encoder1/2_data_out, extrinsic_out    : [BPS][SYMBOLS] arrays of BITS words
//   frames_out                            : emitted frame count (wrapping)
// Modports: master = source/decoder side, slave = the assembler.
//
// Handshake: a word moves on a rising clk edge where llr_in_valid and
// llr_in_ready are both 1. The source holds llr_in stable while valid is
// high and ready is low. llr_in_ready never depends on llr_in_valid.
// ---------------------------------------------------------------------------
interface llr_frame_assembler_if #(
  parameter int BITS    = 32,
  parameter int BPS     = 2,
  parameter int SYMBOLS = 10
);
  logic [BITS-1:0]                        llr_in;
  logic                                   llr_in_valid;
  logic                                   llr_in_ready;
  logic                                   decoder_ready;
  logic                                   out_valid;
  logic [BPS-1:0][SYMBOLS-1:0][BITS-1:0]  encoder1_data_out;
  logic [BPS-1:0][SYMBOLS-1:0][BITS-1:0]  encoder2_data_out;
  logic [BPS-1:0][SYMBOLS-1:0][BITS-1:0]  extrinsic_out;
  logic [15:0]                            frames_out;

  modport master (
    output llr_in, llr_in_valid, decoder_ready,
    input  llr_in_ready, out_valid, encoder1_data_out, encoder2_data_out,
           extrinsic_out, frames_out
  );

  modport slave (
    input  llr_in, llr_in_valid, decoder_ready,
    output llr_in_ready, out_valid, encoder1_data_out, encoder2_data_out,
           extrinsic_out, frames_out
  );
endinterface

// File: rtl/llr_frame_assembler.sv
// ---------------------------------------------------------------------------
// llr_frame_assembler
// Collects one turbo frame of channel LLR words from a serial stream into a
// capture buffer, then hands it to the SISO decoder as registered arrays with
// a one-cycle out_valid strobe once the decoder reports ready.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   flush        synchronous discard of partial or held frame
//   bus          llr_frame_assembler_if.slave (stream in, frame out)
//   o_dbg_state  current FSM state (0 = FILL, 1 = HOLD)
// Word n of a frame lands in symbol n/(2*BPS), encoder (n/BPS)%2,
// bit n%BPS. Extrinsic output is zero: it feeds the first half-iteration.
// ---------------------------------------------------------------------------
module llr_frame_assembler #(
  parameter int BITS            = 32,
  parameter int BITS_PER_SYMBOL = 2,
  parameter int SYMBOLS         = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  llr_frame_assembler_if.slave  bus,
  output logic                  o_dbg_state
);

  localparam int BW = (BITS_PER_SYMBOL > 1) ? $clog2(BITS_PER_SYMBOL) : 1;
  localparam int SW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_SYMBOL - 1);
  localparam logic [SW-1:0] SYM_LAST = SW'(SYMBOLS - 1);

  typedef logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0][BITS-1:0] frame_arr_t;
  typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;

  state_t        r_state;
  logic [BW-1:0] r_bit_idx;
  logic          r_enc_idx;
  logic [SW-1:0] r_sym_idx;
  frame_arr_t    r_cap1, r_cap2;
  frame_arr_t    r_out1, r_out2;
  logic          r_out_valid;
  logic [15:0]   r_frames;

  logic w_ready;
  logic w_xfer;
  logic w_last_word;

  // Ready is forced low while reset is asserted so nothing transfers then.
  assign w_ready     = (r_state == S_FILL) && !reset;
  // A word presented on a flush edge is dropped.
  assign w_xfer      = bus.llr_in_valid && w_ready && !flush;
  assign w_last_word = (r_bit_idx == BIT_LAST) && r_enc_idx &&
                       (r_sym_idx == SYM_LAST);

  // Capture buffer has no reset: its contents are only observable after a
  // full frame has been written, so stale data never escapes.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      if (!r_enc_idx) r_cap1[r_bit_idx][r_sym_idx] <= bus.llr_in;
      else            r_cap2[r_bit_idx][r_sym_idx] <= bus.llr_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_FILL;
      r_bit_idx   <= '0;
      r_enc_idx   <= 1'b0;
      r_sym_idx   <= '0;
      r_out1      <= '0;
      r_out2      <= '0;
      r_out_valid <= 1'b0;
      r_frames    <= '0;
    end else if (flush) begin
      // Drops any partial or held frame; output arrays and count are kept.
      r_state     <= S_FILL;
      r_bit_idx   <= '0;
      r_enc_idx   <= 1'b0;
      r_sym_idx   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_xfer) begin
            // bit_idx innermost, then enc_idx, then sym_idx.
            if (r_bit_idx == BIT_LAST) begin
              r_bit_idx <= '0;
              r_enc_idx <= ~r_enc_idx;
              if (r_enc_idx) begin
                r_sym_idx <= (r_sym_idx == SYM_LAST) ? '0 : r_sym_idx + 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_last_word) r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.decoder_ready) begin
            r_out1      <= r_cap1;
            r_out2      <= r_cap2;
            r_out_valid <= 1'b1;
            r_frames    <= r_frames + 16'd1;
            r_state     <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign bus.llr_in_ready      = w_ready;
  assign bus.out_valid         = r_out_valid;
  assign bus.encoder1_data_out = r_out1;
  assign bus.encoder2_data_out = r_out2;
  assign bus.extrinsic_out     = '0;
  assign bus.frames_out        = r_frames;
  assign o_dbg_state           = r_state;

endmodule

// File: doc/llr_frame_assembler.md
# llr_frame_assembler

Upstream feeder for `soft_in_soft_out` in the turbo decoder. Accepts a serial stream of channel LLR words (raw 32-bit single-precision patterns) over a valid/ready handshake. Assembles one frame of systematic/parity LLRs for both constituent encoders. Presents the frame as the `[BITS_PER_SYMBOL][SYMBOLS]` arrays with a one-cycle `out_valid` pulse, which drives the decoder's `in_valid`. Extrinsic output is all-zero because it feeds the first half-iteration.

## Interface
- `BITS`, 32, LLR word width (bit pattern only; no arithmetic performed)
- `BITS_PER_SYMBOL`, 2, LLRs per symbol per encoder
- `SYMBOLS`, 10, symbols per frame
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `flush`  input  1  synchronous discard of partial or held frame
- `llr_in`  input  BITS  serial LLR word
- `llr_in_valid`  input  1  `llr_in` valid
- `llr_in_ready`  output  1  block can accept a word
- `decoder_ready`  input  1  downstream decoder idle and able to take a frame
- `out_valid`  output  1  one-cycle frame strobe
- `encoder1_data_out`  output  BITS x [BITS_PER_SYMBOL][SYMBOLS]  encoder-1 LLRs
- `encoder2_data_out`  output  BITS x [BITS_PER_SYMBOL][SYMBOLS]  encoder-2 LLRs
- `extrinsic_out`  output  BITS x [BITS_PER_SYMBOL][SYMBOLS]  constant 0
- `frames_out`  output  16  count of emitted frames, wraps 0xFFFF→0

## Operation
- Frame length F = 2·BITS_PER_SYMBOL·SYMBOLS words.
- Stream order within a frame:
  - Word n maps to symbol j = n / (2·BPS), encoder e = (n / BPS) mod 2, and bit i = n mod BPS.
  - e=0 writes capture buffer enc1[i][j]; e=1 writes enc2[i][j].
- Counters: `bit_idx` (0..BPS-1), `enc_idx` (0..1), `sym_idx` (0..SYMBOLS-1), nested in that order and cleared at frame end.
- A word transfers on a rising edge where `llr_in_valid` && `llr_in_ready`.
- States:
  - FILL: `llr_in_ready`=1. The transfer of word F-1 moves the block to HOLD.
  - HOLD: `llr_in_ready`=0. An edge with `decoder_ready`=1 copies the capture buffer into the output registers, sets `out_valid`=1, increments `frames_out`, and moves the block to FILL.
- Output arrays are registered copies. They change only on the emit edge and are held stable until the next emit, so the capture buffer can refill while the decoder runs.
- `out_valid` is registered, high for exactly one cycle per frame, and never high on two consecutive cycles.
- `flush`:
  - Priority below `reset`, above everything else.
  - Clears the counters and moves the block to FILL. A held frame is discarded and no `out_valid` is issued on that edge.
  - A word presented on a flush edge is not captured.
  - Output arrays and `frames_out` are untouched.
- Flush and emit on the same edge: flush wins, no `out_valid`, `frames_out` unchanged.
- Words presented with `llr_in_valid`=1 while in HOLD are not consumed (`ready`=0). The source must hold them.
- `extrinsic_out` is tied to all zeros.

## Timing
- Reset values:
  - state FILL, counters 0, `out_valid` 0, `frames_out` 0, all output arrays 0.
  - `llr_in_ready` is forced 0 while `reset` is high and is 1 in the first cycle after release.
- `llr_in_ready` is a combinational decode of state, with no dependence on `llr_in_valid`.
- Latency, with `decoder_ready` already high: last word accepted at edge E; `out_valid` high in the cycle following edge E+1; `llr_in_ready` high again after E+1.
- Minimum frame period: F+1 cycles (F transfers + 1 emit cycle).
- If `decoder_ready` is low in HOLD, the block waits indefinitely. Emit occurs on the first edge at which `decoder_ready`=1.
- Reset asserted mid-frame or in HOLD: immediate return to reset values, partial frame lost.

## Test plan
- Reset then 40 words with values n+1 (integer patterns 1..40), `decoder_ready`=1, valid continuous:
  - `out_valid` is one pulse 1 cycle after the 40th transfer.
  - enc1[0][0]=1, enc1[1][0]=2, enc2[0][0]=3, enc2[1][0]=4.
  - enc1[0][9]=37, enc2[1][9]=40.
  - extrinsic all 0; `frames_out`=1.
- `decoder_ready` held low for 20 cycles after a full frame:
  - `llr_in_ready`=0 throughout; no `out_valid`.
  - Emit occurs on the first edge with `decoder_ready`=1.
  - Pending input word is then accepted as word 0 of the next frame.
- Random gaps in `llr_in_valid` (~50%):
  - Identical output arrays to the first test.
  - Output arrays unchanged while the second frame fills.
- `flush` after 17 words, then a fresh 40-word frame with values 101..140:
  - Single `out_valid`; enc1[0][0]=101, enc2[1][9]=140; `frames_out` increments by 1 only.
- `flush` and `decoder_ready` both high on the emit edge:
  - No `out_valid`, `frames_out` unchanged.
  - Outputs retain the previous frame; block returns to FILL.
- `reset` pulsed asynchronously (between clock edges) at word 25:
  - All outputs return to reset values immediately.
  - Next 40-word frame emits correctly with `frames_out`=1.
